tile_spawner: RTL and testbench
===============================

Name: tile_spawner

Overview:
- Controller that turns the free-running 4-bit random_num output into a legal new-tile placement for the 2048 game after every move.
- On a spawn request it snapshots the board's empty-cell mask and uses the random value as a start index. It then scans the 4x4 board, one cell per cycle with wrap-around, until it finds an empty cell.
- It presents {cell index, tile value 2/4} on a valid/ack handshake to the board-update logic, and flags a full board.

Parameters:
- CELLS, 16, number of board cells (4x4); index width is $clog2(CELLS) = 4.
- FOUR_BITS, 3, a tile of 4 is chosen when the low FOUR_BITS of rnd are all ones (P = 1/8); otherwise a tile of 2.
- CNT_W, 8, width of the spawn statistics counter.

Ports:
- clk  input  1  system clock; all state is updated on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- rnd  input  4  random value from random_num, sampled directly.
- spawn_req  input  1  request a new tile; sampled only in IDLE.
- empty_mask  input  CELLS  bit i = 1 means cell i is empty; sampled on request accept.
- spawn_ack  input  1  consumer has taken the spawn result.
- spawn_valid  output  1  spawn_idx and spawn_val are valid.
- spawn_idx  output  4  target cell index, 0..15.
- spawn_val  output  1  0 = tile 2, 1 = tile 4.
- busy  output  1  high in SCAN and HOLD.
- no_space  output  1  one-cycle pulse: request arrived while the board is full.
- spawn_cnt  output  CNT_W  count of completed spawns; wraps.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-SCAN or mid-HOLD):
  - state goes to IDLE;
  - all outputs are 0;
  - mask_q, ptr and spawn_cnt are 0;
  - any in-flight request is dropped.
- States: IDLE, SCAN, HOLD.
- IDLE:
  - spawn_req=1 and empty_mask!=0: latch mask_q <= empty_mask and ptr <= rnd, then go to SCAN.
  - spawn_req=1 and empty_mask==0: no_space=1 for the next cycle only; stay in IDLE; busy stays 0.
- SCAN, each cycle:
  - mask_q[ptr]=1: spawn_idx <= ptr, spawn_val <= &rnd[FOUR_BITS-1:0] (rnd sampled in this cycle), spawn_valid <= 1, go to HOLD.
  - mask_q[ptr]=0: ptr <= ptr+1 mod 16 (15 wraps to 0).
  - The scan terminates in at most 16 cycles because mask_q!=0 is guaranteed.
- Latency: spawn_valid rises k+1 cycles after the accept edge, where k = (first_empty - start) mod 16, in the range 0..15.
- HOLD:
  - spawn_valid, spawn_idx and spawn_val are held stable until spawn_ack=1.
  - On ack: spawn_valid <= 0, spawn_cnt <= spawn_cnt+1 (255 wraps to 0), go to IDLE.
  - busy falls in the same cycle that spawn_valid falls.
  - spawn_ack asserted in the same cycle valid first rises is accepted at the next edge.
- spawn_req outside IDLE is ignored; it is not queued.
- spawn_ack outside HOLD is ignored.
- empty_mask changes after accept are ignored, because the block uses only its snapshot mask_q.
- spawn_idx and spawn_val keep their last values after ack; they are meaningful only while spawn_valid=1.
- A request in the IDLE cycle right after an ack is accepted normally.

Decomposition:
- Shared package tile_pkg:
  - CELLS and IDX_W constants;
  - spawn_state_t enum {IDLE, SCAN, HOLD};
  - tile-value encoding constants TILE_2=0 and TILE_4=1, also used by the board and display logic.
- No sub-module. random_num is instantiated at the top level and its num output is wired to rnd, so a bench can drive rnd directly.

Test Plan:
- Direct hit: empty_mask=16'h0020, rnd=5 at accept, rnd=4'b0000 in the find cycle -> spawn_valid rises 1 cycle after accept, idx=5, val=0.
- Wrap-around scan: empty_mask=16'h0002, rnd=14 at accept -> ptr visits 14, 15, 0, 1; valid rises 4 cycles after accept with idx=1; busy is high throughout.
- Full board: empty_mask=16'h0000 with spawn_req -> no_space high for exactly 1 cycle; busy=0 and spawn_valid=0 throughout.
- Tile-4 selection and mask snapshot: empty_mask=16'h8000, rnd=15, then rnd=4'b0111 in the find cycle while empty_mask is changed to 0 -> idx=15, val=1.
- Handshake hold: ack withheld 5 cycles with extra spawn_req pulses -> valid, idx and val stay stable and no new scan starts; on ack, spawn_cnt goes 0->1 and busy drops. After 256 spawns, spawn_cnt wraps to 0.
- Reset mid-scan: rst pulsed during SCAN (empty_mask=16'h0001, start=1) -> busy, spawn_valid and spawn_cnt go to 0 immediately without a clock edge; after release a fresh request completes normally.

Source files
------------

// File: rtl/tile_pkg.sv
// Shared definitions for the 2048 tile spawner and the board/display logic
// that consume its placement results.
package tile_pkg;

    localparam int CELLS = 16;
    localparam int IDX_W = $clog2(CELLS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        HOLD = 2'd2
    } spawn_state_t;

    // Tile-value encoding carried on spawn_val
    localparam logic TILE_2 = 1'b0;
    localparam logic TILE_4 = 1'b1;

endpackage

// File: rtl/tile_spawner.sv
// Picks a cell for the next 2048 tile: snapshot the empty mask, scan from a
// random start with wrap-around, then offer {idx, val} on a valid/ack handshake.
module tile_spawner #(
    parameter int CELLS     = tile_pkg::CELLS,
    parameter int FOUR_BITS = 3,
    parameter int CNT_W     = 8,
    localparam int IW       = $clog2(CELLS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IW-1:0]    rnd,
    input  logic             spawn_req,
    input  logic [CELLS-1:0] empty_mask,
    input  logic             spawn_ack,
    output logic             spawn_valid,
    output logic [IW-1:0]    spawn_idx,
    output logic             spawn_val,
    output logic             busy,
    output logic             no_space,
    output logic [CNT_W-1:0] spawn_cnt
);
    import tile_pkg::*;

    spawn_state_t     state_q, state_d;
    logic [CELLS-1:0] mask_q, mask_d;
    logic [IW-1:0]    ptr_q, ptr_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             val_q, val_d;
    logic             valid_q, valid_d;
    logic             no_space_q, no_space_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             four_sel;
    logic [IW-1:0]    ptr_inc;

    assign four_sel = &rnd[FOUR_BITS-1:0];
    assign ptr_inc  = (ptr_q == IW'(CELLS - 1)) ? '0 : ptr_q + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            mask_q     <= '0;
            ptr_q      <= '0;
            idx_q      <= '0;
            val_q      <= 1'b0;
            valid_q    <= 1'b0;
            no_space_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            mask_q     <= mask_d;
            ptr_q      <= ptr_d;
            idx_q      <= idx_d;
            val_q      <= val_d;
            valid_q    <= valid_d;
            no_space_q <= no_space_d;
            cnt_q      <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        mask_d     = mask_q;
        ptr_d      = ptr_q;
        idx_d      = idx_q;
        val_d      = val_q;
        valid_d    = valid_q;
        no_space_d = 1'b0;
        cnt_d      = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (spawn_req) begin
                    if (|empty_mask) begin
                        mask_d  = empty_mask;
                        ptr_d   = rnd;
                        state_d = SCAN;
                    end else begin
                        no_space_d = 1'b1;
                    end
                end
            end
            SCAN: begin
                // Scan always terminates: the snapshot is known non-zero
                if (mask_q[ptr_q]) begin
                    idx_d   = ptr_q;
                    val_d   = four_sel ? TILE_4 : TILE_2;
                    valid_d = 1'b1;
                    state_d = HOLD;
                end else begin
                    ptr_d = ptr_inc;
                end
            end
            HOLD: begin
                if (spawn_ack) begin
                    valid_d = 1'b0;
                    cnt_d   = cnt_q + 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign spawn_valid = valid_q;
    assign spawn_idx   = idx_q;
    assign spawn_val   = val_q;
    assign busy        = (state_q == SCAN) || (state_q == HOLD);
    assign no_space    = no_space_q;
    assign spawn_cnt   = cnt_q;

endmodule

// File: tb/tb_tile_spawner.sv
// Directed bench for tile_spawner: inputs driven and outputs sampled on the
// falling clock edge, one line per transaction.
module tb_tile_spawner;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  rnd;
    logic        spawn_req;
    logic [15:0] empty_mask;
    logic        spawn_ack;
    logic        spawn_valid;
    logic [3:0]  spawn_idx;
    logic        spawn_val;
    logic        busy;
    logic        no_space;
    logic [7:0]  spawn_cnt;

    int vec  = 0;
    int errs = 0;
    logic [7:0] exp_cnt = 8'd0;

    always #5 clk = ~clk;

    tile_spawner #(.CELLS(16), .FOUR_BITS(3), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .rnd(rnd), .spawn_req(spawn_req),
        .empty_mask(empty_mask), .spawn_ack(spawn_ack),
        .spawn_valid(spawn_valid), .spawn_idx(spawn_idx), .spawn_val(spawn_val),
        .busy(busy), .no_space(no_space), .spawn_cnt(spawn_cnt)
    );

    // Drive one request; returns edges from accept to valid (-1 on timeout).
    task automatic spawn_run(input logic [15:0] m, input logic [3:0] s,
                             input logic [3:0] fr, input logic [15:0] m_after,
                             output int lat, output logic [3:0] idx_o,
                             output logic val_o, output bit busy_hi);
        spawn_req = 1'b1; empty_mask = m; rnd = s;
        @(negedge clk);
        spawn_req = 1'b0; rnd = fr; empty_mask = m_after;
        lat = 0; busy_hi = 1'b1;
        while (spawn_valid !== 1'b1 && lat < 40) begin
            busy_hi &= (busy === 1'b1);
            @(negedge clk);
            lat++;
        end
        if (spawn_valid !== 1'b1) lat = -1;
        idx_o = spawn_idx; val_o = spawn_val;
    endtask

    task automatic do_ack();
        spawn_ack = 1'b1;
        @(negedge clk);
        spawn_ack = 1'b0;
        exp_cnt++;
    endtask

    task automatic test_reset();
        rst = 1'b1; rnd = 4'd0; spawn_req = 1'b0; empty_mask = 16'h0; spawn_ack = 1'b0;
        repeat (2) @(negedge clk);
        vec++;
        if ({spawn_valid, spawn_idx, spawn_val, busy, no_space, spawn_cnt} !== 16'h0) begin
            errs++;
            $display("FAIL reset_outputs: got valid=%b idx=%0d val=%b busy=%b nospace=%b cnt=%0d, want all 0",
                     spawn_valid, spawn_idx, spawn_val, busy, no_space, spawn_cnt);
        end
        rst = 1'b0;
        @(negedge clk);
        $display("reset: outputs idle after reset");
    endtask

    task automatic test_direct_hit();
        int lat; logic [3:0] idx; logic val; bit bh;
        spawn_run(16'h0020, 4'd5, 4'b0000, 16'h0020, lat, idx, val, bh);
        vec++;
        if (lat !== 1 || idx !== 4'd5 || val !== 1'b0 || !bh) begin
            errs++;
            $display("FAIL direct_hit: got lat=%0d idx=%0d val=%b busy_ok=%0d, want lat=1 idx=5 val=0 busy_ok=1",
                     lat, idx, val, bh);
        end
        do_ack();
        vec++;
        if (spawn_valid !== 1'b0 || busy !== 1'b0 || spawn_cnt !== exp_cnt) begin
            errs++;
            $display("FAIL direct_ack: got valid=%b busy=%b cnt=%0d, want 0 0 %0d",
                     spawn_valid, busy, spawn_cnt, exp_cnt);
        end
        $display("direct_hit: idx=%0d val=%b lat=%0d cnt=%0d", idx, val, lat, spawn_cnt);
    endtask

    task automatic test_wrap_scan();
        int lat; logic [3:0] idx; logic val; bit bh;
        spawn_run(16'h0002, 4'd14, 4'b0001, 16'h0002, lat, idx, val, bh);
        vec++;
        if (lat !== 4 || idx !== 4'd1 || val !== 1'b0 || !bh) begin
            errs++;
            $display("FAIL wrap_scan: got lat=%0d idx=%0d val=%b busy_ok=%0d, want lat=4 idx=1 val=0 busy_ok=1",
                     lat, idx, val, bh);
        end
        do_ack();
        $display("wrap_scan: idx=%0d lat=%0d", idx, lat);
    endtask

    task automatic test_full_board();
        bit ok_busy = 1'b1;
        int hi_cycles = 0;
        spawn_req = 1'b1; empty_mask = 16'h0000;
        @(negedge clk);
        spawn_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (no_space === 1'b1) hi_cycles++;
            if (busy !== 1'b0 || spawn_valid !== 1'b0) ok_busy = 1'b0;
            if (i == 0) begin
                vec++;
                if (no_space !== 1'b1) begin
                    errs++;
                    $display("FAIL full_nospace_pulse: got no_space=%b, want 1", no_space);
                end
            end
            @(negedge clk);
        end
        vec++;
        if (hi_cycles !== 1 || !ok_busy) begin
            errs++;
            $display("FAIL full_board: got no_space cycles=%0d busy/valid quiet=%0d, want 1 and 1",
                     hi_cycles, ok_busy);
        end
        $display("full_board: no_space cycles=%0d", hi_cycles);
    endtask

    task automatic test_tile4_snapshot();
        int lat; logic [3:0] idx; logic val; bit bh;
        spawn_run(16'h8000, 4'd15, 4'b0111, 16'h0000, lat, idx, val, bh);
        vec++;
        if (lat !== 1 || idx !== 4'd15 || val !== 1'b1) begin
            errs++;
            $display("FAIL tile4_snapshot: got lat=%0d idx=%0d val=%b, want lat=1 idx=15 val=1",
                     lat, idx, val);
        end
        do_ack();
        $display("tile4_snapshot: idx=%0d val=%b", idx, val);
    endtask

    task automatic test_hold();
        int lat; logic [3:0] idx; logic val; bit bh;
        bit stable = 1'b1;
        spawn_run(16'h0100, 4'd8, 4'b0000, 16'h0100, lat, idx, val, bh);
        vec++;
        if (lat !== 1 || idx !== 4'd8 || val !== 1'b0) begin
            errs++;
            $display("FAIL hold_setup: got lat=%0d idx=%0d val=%b, want 1 8 0", lat, idx, val);
        end
        for (int i = 0; i < 5; i++) begin
            spawn_req = ~spawn_req; empty_mask = 16'h0F0F; rnd = 4'b0111;
            @(negedge clk);
            if (spawn_valid !== 1'b1 || spawn_idx !== 4'd8 || spawn_val !== 1'b0 || busy !== 1'b1)
                stable = 1'b0;
        end
        spawn_req = 1'b0;
        vec++;
        if (!stable || spawn_cnt !== exp_cnt) begin
            errs++;
            $display("FAIL hold_stable: got stable=%0d cnt=%0d idx=%0d, want 1 %0d 8",
                     stable, spawn_cnt, spawn_idx, exp_cnt);
        end
        do_ack();
        vec++;
        if (spawn_valid !== 1'b0 || busy !== 1'b0 || spawn_cnt !== exp_cnt) begin
            errs++;
            $display("FAIL hold_ack: got valid=%b busy=%b cnt=%0d, want 0 0 %0d",
                     spawn_valid, busy, spawn_cnt, exp_cnt);
        end
        $display("hold: held 5 cycles, cnt=%0d", spawn_cnt);
    endtask

    task automatic test_back_to_back();
        int lat; logic [3:0] idx; logic val; bit bh;
        // Request in the IDLE cycle right after an ack; ack held early (ignored in SCAN)
        spawn_ack = 1'b1;
        spawn_run(16'h0C00, 4'd9, 4'b1111, 16'h0C00, lat, idx, val, bh);
        vec++;
        if (lat !== 2 || idx !== 4'd10 || val !== 1'b1 || spawn_cnt !== exp_cnt) begin
            errs++;
            $display("FAIL b2b_find: got lat=%0d idx=%0d val=%b cnt=%0d, want 2 10 1 %0d",
                     lat, idx, val, spawn_cnt, exp_cnt);
        end
        @(negedge clk);
        spawn_ack = 1'b0;
        exp_cnt++;
        vec++;
        if (spawn_valid !== 1'b0 || busy !== 1'b0 || spawn_cnt !== exp_cnt) begin
            errs++;
            $display("FAIL b2b_ack: got valid=%b busy=%b cnt=%0d, want 0 0 %0d",
                     spawn_valid, busy, spawn_cnt, exp_cnt);
        end
        $display("back_to_back: idx=%0d val=%b cnt=%0d", idx, val, spawn_cnt);
    endtask

    task automatic test_reset_mid_scan();
        int lat; logic [3:0] idx; logic val; bit bh;
        spawn_req = 1'b1; empty_mask = 16'h0001; rnd = 4'd1;
        @(negedge clk);
        spawn_req = 1'b0;
        repeat (3) @(negedge clk);
        vec++;
        if (busy !== 1'b1 || spawn_cnt !== exp_cnt) begin
            errs++;
            $display("FAIL midscan_busy: got busy=%b cnt=%0d, want 1 %0d", busy, spawn_cnt, exp_cnt);
        end
        #2 rst = 1'b1;
        #1;
        vec++;
        if (busy !== 1'b0 || spawn_valid !== 1'b0 || spawn_cnt !== 8'd0) begin
            errs++;
            $display("FAIL async_reset: got busy=%b valid=%b cnt=%0d, want 0 0 0",
                     busy, spawn_valid, spawn_cnt);
        end
        @(negedge clk);
        rst = 1'b0;
        exp_cnt = 8'd0;
        @(negedge clk);
        spawn_run(16'h0001, 4'd1, 4'b0000, 16'h0001, lat, idx, val, bh);
        vec++;
        if (lat !== 16 || idx !== 4'd0 || !bh) begin
            errs++;
            $display("FAIL post_reset_spawn: got lat=%0d idx=%0d busy_ok=%0d, want 16 0 1", lat, idx, bh);
        end
        do_ack();
        vec++;
        if (spawn_cnt !== exp_cnt) begin
            errs++;
            $display("FAIL post_reset_cnt: got cnt=%0d, want %0d", spawn_cnt, exp_cnt);
        end
        $display("reset_mid_scan: recovered, lat=%0d cnt=%0d", lat, spawn_cnt);
    endtask

    task automatic test_cnt_wrap();
        int lat; logic [3:0] idx; logic val; bit bh;
        while (exp_cnt != 8'd255) begin
            spawn_run(16'hFFFF, exp_cnt[3:0], 4'b0000, 16'hFFFF, lat, idx, val, bh);
            do_ack();
        end
        vec++;
        if (spawn_cnt !== 8'd255) begin
            errs++;
            $display("FAIL cnt_255: got cnt=%0d, want 255", spawn_cnt);
        end
        spawn_run(16'hFFFF, 4'd3, 4'b0000, 16'hFFFF, lat, idx, val, bh);
        do_ack();
        vec++;
        if (spawn_cnt !== 8'd0 || exp_cnt !== 8'd0) begin
            errs++;
            $display("FAIL cnt_wrap: got cnt=%0d, want 0", spawn_cnt);
        end
        $display("cnt_wrap: cnt=%0d after wrap", spawn_cnt);
    endtask

    initial begin
        test_reset();
        test_direct_hit();
        test_wrap_scan();
        test_full_board();
        test_tile4_snapshot();
        test_hold();
        test_back_to_back();
        test_reset_mid_scan();
        test_cnt_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
